// File: rtl/hazard.sv
`default_nettype none
// ============================================================================
// Module   : hazard
// Purpose  : Pipeline hazard unit for the 5-stage MIPS core. Produces the
//            stall, flush and forwarding selects and sequences the
//            multi-cycle divider through a start/done handshake. F, D and E
//            stay frozen until the divider result is ready.
// Ports    : clk                  rising-edge clock
//            rst                  asynchronous, active-low reset
//            rsD/rtD, branchD     D-stage sources and branch flag
//            rsE/rtE/writeregE    E-stage register numbers
//            regwriteE/memtoregE  E-stage control
//            divE, div_done       divider request / result-valid pulse
//            writeregM, regwriteM, memtoregM, writeregW, regwriteW
//            stallF/D/E, flushE/M stall and bubble controls
//            forwardaD/bD         D-comparator bypass from M
//            forwardaE/bE         ALU operand select (00 RF, 01 W, 10 M)
//            div_start            one-cycle divider launch pulse
//            *_stall_cnt          saturating stall statistics
// Config   : define HAZARD_PERF_EN to build the stall counters; when it is
//            undefined the counter ports are tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module hazard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             branchD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             divE,
  input  logic             div_done,
  input  logic [4:0]       writeregM,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushE,
  output logic             flushM,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             div_start,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt,
  output logic [CNT_W-1:0] div_stall_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] divState;
  logic [1:0] divStateNext;
  logic       lwStall;
  logic       branchStall;
  logic       divStall;

  // E-stage operand select: M has priority over W, register 0 never forwards.
  always_comb begin
    forwardaE = 2'b00;
    if (rsE != 5'd0 && rsE == writeregM && regwriteM)      forwardaE = 2'b10;
    else if (rsE != 5'd0 && rsE == writeregW && regwriteW) forwardaE = 2'b01;

    forwardbE = 2'b00;
    if (rtE != 5'd0 && rtE == writeregM && regwriteM)      forwardbE = 2'b10;
    else if (rtE != 5'd0 && rtE == writeregW && regwriteW) forwardbE = 2'b01;
  end

  assign forwardaD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;

  assign lwStall = memtoregE && ((rsD == rtE) || (rtD == rtE));

  // The branch comparator lives in D, so it must wait for an ALU result still
  // in E or a load result still in M.
  assign branchStall = branchD &&
                       ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                        (memtoregM && (writeregM == rsD || writeregM == rtD)));

  // DONE is a one-cycle grace state: the finished DIV is still in E with
  // divE high and must leave without relaunching the divider.
  always_comb begin
    divStateNext = IDLE;
    case (divState)
      IDLE:    divStateNext = divE ? BUSY : IDLE;
      BUSY:    divStateNext = div_done ? DONE : BUSY;
      DONE:    divStateNext = IDLE;
      default: divStateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) divState <= IDLE;
    else      divState <= divStateNext;
  end

  assign divStall = ((divState == IDLE) && divE) || (divState == BUSY);

  // Gated with rst so the launch pulse drops the moment reset is asserted,
  // even while divE is still high.
  assign div_start = rst && (divState == IDLE) && divE;

  assign stallF = lwStall || branchStall || divStall;
  assign stallD = stallF;
  assign stallE = divStall;
  assign flushM = divStall;
  // A frozen E register holds the DIV and must never be bubbled.
  assign flushE = (lwStall || branchStall) && !divStall;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lwCnt;
  logic [CNT_W-1:0] brCnt;
  logic [CNT_W-1:0] divCnt;

  // Each stall cycle is charged to one cause only: divide, then load, then branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lwCnt  <= '0;
      brCnt  <= '0;
      divCnt <= '0;
    end else begin
      if (lwStall && !divStall && lwCnt != '1)
        lwCnt <= lwCnt + CNT_W'(1);
      if (branchStall && !divStall && !lwStall && brCnt != '1)
        brCnt <= brCnt + CNT_W'(1);
      if (divStall && divCnt != '1)
        divCnt <= divCnt + CNT_W'(1);
    end
  end

  assign lw_stall_cnt  = lwCnt;
  assign br_stall_cnt  = brCnt;
  assign div_stall_cnt = divCnt;
`else
  assign lw_stall_cnt  = '0;
  assign br_stall_cnt  = '0;
  assign div_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard
// Purpose  : Self-checking bench for the hazard unit. Directed scenarios are
//            followed by randomized traffic; all outputs are compared every
//            cycle against a behavioural model of the hazard rules and of the
//            divider occupancy.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, regwriteE, memtoregE, divE, div_done;
  logic regwriteM, memtoregM, regwriteW;
  logic stallF, stallD, stallE, flushE, flushM, forwardaD, forwardbD, div_start;
  logic [1:0] forwardaE, forwardbE;
  logic [CNT_W-1:0] lw_stall_cnt, br_stall_cnt, div_stall_cnt;

  int total = 0;
  int bad   = 0;

  // Model of divider occupancy: is a divide outstanding, and is the finished
  // DIV still sitting in E for its one exit cycle.
  bit     divOutstanding;
  bit     divExiting;
  longint lwCount, brCount, divCount;

  hazard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE),
    .divE(divE), .div_done(div_done),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .div_start(div_start),
    .lw_stall_cnt(lw_stall_cnt), .br_stall_cnt(br_stall_cnt),
    .div_stall_cnt(div_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdE(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (regwriteM && src == writeregM) return 2'b10;
    if (regwriteW && src == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mLw();
    return memtoregE && (rsD == rtE || rtD == rtE);
  endfunction

  function automatic bit mBr();
    bit eHit, mHit;
    eHit = regwriteE && (writeregE == rsD || writeregE == rtD);
    mHit = memtoregM && (writeregM == rsD || writeregM == rtD);
    return branchD && (eHit || mHit);
  endfunction

  // A DIV in E is frozen while it waits to launch or waits for its result.
  function automatic bit mDiv();
    return divOutstanding || (!divExiting && divE);
  endfunction

  function automatic longint sat(input longint v);
    longint maxv;
    maxv = (longint'(1) << CNT_W) - 1;
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic checkAll(input string ctx);
    bit lw, br, dv;
    lw = mLw(); br = mBr(); dv = mDiv();
    chk({ctx, ":stallF"}, stallF, lw | br | dv);
    chk({ctx, ":stallD"}, stallD, lw | br | dv);
    chk({ctx, ":stallE"}, stallE, dv);
    chk({ctx, ":flushE"}, flushE, (lw | br) & ~dv);
    chk({ctx, ":flushM"}, flushM, dv);
    chk({ctx, ":fwdaD"}, forwardaD, rsD != 0 && regwriteM && rsD == writeregM);
    chk({ctx, ":fwdbD"}, forwardbD, rtD != 0 && regwriteM && rtD == writeregM);
    chk({ctx, ":fwdaE"}, forwardaE, fwdE(rsE));
    chk({ctx, ":fwdbE"}, forwardbE, fwdE(rtE));
    chk({ctx, ":divStart"}, div_start,
        rst && !divOutstanding && !divExiting && divE);
`ifdef HAZARD_PERF_EN
    chk({ctx, ":lwCnt"},  lw_stall_cnt,  32'(lwCount));
    chk({ctx, ":brCnt"},  br_stall_cnt,  32'(brCount));
    chk({ctx, ":divCnt"}, div_stall_cnt, 32'(divCount));
`else
    chk({ctx, ":lwCnt"},  lw_stall_cnt,  32'd0);
    chk({ctx, ":brCnt"},  br_stall_cnt,  32'd0);
    chk({ctx, ":divCnt"}, div_stall_cnt, 32'd0);
`endif
  endtask

  task automatic modelClear();
    divOutstanding = 0; divExiting = 0;
    lwCount = 0; brCount = 0; divCount = 0;
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic modelTick();
    bit lw, br, dv;
    if (!rst) begin
      modelClear();
      return;
    end
    lw = mLw(); br = mBr(); dv = mDiv();
    if (lw && !dv) lwCount = sat(lwCount + 1);
    if (br && !dv && !lw) brCount = sat(brCount + 1);
    if (dv) divCount = sat(divCount + 1);
    if (divExiting) divExiting = 0;
    else if (divOutstanding) begin
      if (div_done) begin divOutstanding = 0; divExiting = 1; end
    end else if (divE) divOutstanding = 1;
  endtask

  task automatic step(input string ctx);
    #1 checkAll(ctx);
    @(posedge clk);
    modelTick();
    #1;
  endtask

  task automatic idleInputs();
    rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0; writeregE = 0;
    regwriteE = 0; memtoregE = 0; divE = 0; div_done = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0; writeregW = 0; regwriteW = 0;
  endtask

  initial begin
    idleInputs();
    rst = 1'b0;
    modelClear();
    #2 checkAll("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Forwarding priority
    rsE = 8; writeregM = 8; regwriteM = 1; writeregW = 8; regwriteW = 1;
    #1 chk("fwd_M_prio", forwardaE, 2'b10);
    step("fwdM");
    regwriteM = 0;
    #1 chk("fwd_W", forwardaE, 2'b01);
    step("fwdW");
    rsE = 0; writeregM = 0; writeregW = 0; regwriteM = 1;
    #1 chk("fwd_r0", forwardaE, 2'b00);
    step("fwd0");
    idleInputs();

    // Load-use
    memtoregE = 1; rtE = 9; rsD = 9;
    #1 chk("lw_flushE", flushE, 1'b1);
    chk("lw_stallE", stallE, 1'b0);
    step("lw");
    memtoregE = 0;
    #1 chk("lw_release", stallF, 1'b0);
    step("lwRel");
    idleInputs();

    // Branch against E, then against an M ALU result (forwarded)
    branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    #1 chk("br_stallD", stallD, 1'b1);
    step("brE");
    regwriteE = 0; writeregE = 0; writeregM = 4; regwriteM = 1;
    #1 chk("br_fwdaD", forwardaD, 1'b1);
    chk("br_nostall", stallD, 1'b0);
    step("brM");
    idleInputs();

    // Single DIV, result at cycle 5, then back-to-back DIVs
    divE = 1;
    #1 chk("div_start_pulse", div_start, 1'b1);
    step("div0");
    for (int c = 1; c <= 5; c++) begin
      div_done = (c == 5);
      step("divBusy");
    end
    div_done = 0;
    #1 chk("div_done_release", stallE, 1'b0);
    step("divDone");
    #1 chk("div_relaunch", div_start, 1'b1);
    step("div2Start");
    div_done = 1; step("div2Busy");
    div_done = 0; step("div2Done");
    divE = 0; step("div2Leave");

    // Reset in BUSY, late div_done ignored
    divE = 1; step("div3Start");
    divE = 0; step("div3Busy");
    rst = 0; modelClear();
    #1 chk("rst_div_start", div_start, 1'b0);
    chk("rst_stallE", stallE, 1'b0);
    step("rstHold");
    rst = 1; div_done = 1;
    #1 chk("late_done_stall", stallF, 1'b0);
    step("lateDone");
    idleInputs();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      branchD = 1'($urandom); regwriteE = 1'($urandom); memtoregE = 1'($urandom);
      regwriteM = 1'($urandom); memtoregM = 1'($urandom); regwriteW = 1'($urandom);
      divE = ($urandom_range(0, 3) == 0);
      div_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 0; modelClear();
      end else begin
        rst = 1;
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard.md
Name: hazard

Overview:
- Pipeline hazard unit for the 5-stage MIPS core.
- Consumes the per-stage control and register-address signals produced by the controller and datapath.
- Returns stall, flush and forwarding selects, including the flushE that the controller's E-stage register consumes.
- Also sequences the multi-cycle divider through a start/done handshake, freezing F/D/E until the result is ready.

Parameters:
CNT_W, 32, width of stall-statistics counters (used only with HAZARD_PERF_EN).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
rsD, rtD  in  5  D-stage source register numbers
branchD  in  1  D-stage branch (comparator in D)
rsE, rtE  in  5  E-stage source register numbers
writeregE  in  5  E-stage destination register
regwriteE, memtoregE  in  1  E-stage control
divE  in  1  E-stage instruction is DIV/DIVU
div_done  in  1  divider result valid (single-cycle pulse)
writeregM  in  5  M-stage destination
regwriteM, memtoregM  in  1  M-stage control
writeregW  in  5  W-stage destination
regwriteW  in  1  W-stage control
stallF, stallD, stallE  out  1  hold the PC, D register and E register
flushE, flushM  out  1  bubble into the E and M registers
forwardaD, forwardbD  out  1  D-comparator bypass from M
forwardaE, forwardbE  out  2  ALU operand select: 00 register file, 01 W, 10 M
div_start  out  1  one-cycle divider launch pulse
lw_stall_cnt, br_stall_cnt, div_stall_cnt  out  CNT_W  stall statistics

Behaviour:
- Forwarding (combinational):
  - forwardaE = 10 if rsE != 0, rsE == writeregM and regwriteM.
  - Otherwise forwardaE = 01 if rsE != 0, rsE == writeregW and regwriteW.
  - Otherwise forwardaE = 00. M has priority over W.
  - forwardbE uses the same rules with rtE.
  - forwardaD = (rsD != 0) & (rsD == writeregM) & regwriteM; forwardbD uses the same rule with rtD.
- lwstall = memtoregE & ((rsD == rtE) | (rtD == rtE)).
- branchstall = branchD & ( (regwriteE & (writeregE == rsD | writeregE == rtD)) | (memtoregM & (writeregM == rsD | writeregM == rtD)) ).
- Divider FSM, registered, states IDLE / BUSY / DONE, reset to IDLE:
  - IDLE: if divE, then div_start = 1 that cycle; next state BUSY.
  - BUSY: holds; if div_done, next state DONE.
  - DONE: lasts one cycle, divE is ignored; next state IDLE. This lets the divide instruction leave E without relaunching.
  - div_done in IDLE or DONE is ignored.
  - Back-to-back DIVs: the second one launches in the IDLE cycle following DONE.
- divstall = (state == IDLE & divE) | (state == BUSY). DONE does not stall.
- Output equations:
  - stallF = stallD = lwstall | branchstall | divstall.
  - stallE = divstall.
  - flushM = divstall (bubbles into M while E is frozen).
  - flushE = (lwstall | branchstall) & ~divstall; a frozen E must never be flushed.
- Latency:
  - Forward and stall outputs are combinational, with zero latency from inputs.
  - div_start is a Mealy pulse in the same cycle divE is first seen in IDLE.
  - Minimum DIV occupancy in E = 1 (IDLE) + N (BUSY until div_done) + 1 (DONE) cycles.
- Reset (rst low, any time, including mid-divide):
  - state goes to IDLE and div_start goes to 0 immediately.
  - Any in-flight divide is abandoned, and a late div_done after release is ignored.
  - Combinational outputs follow their equations with state = IDLE.
  - Counters clear to 0.

Optional Feature:
HAZARD_PERF_EN:
- Defined: three saturating CNT_W-bit counters, cleared by reset.
  - lw_stall_cnt increments each cycle lwstall & ~divstall.
  - br_stall_cnt increments each cycle branchstall & ~divstall & ~lwstall.
  - div_stall_cnt increments each cycle divstall.
  - Each counter holds at all-ones.
- Undefined: ports remain present, tied to 0, and no counter flops are instantiated.

Test Plan:
- rsE=8, writeregM=8, regwriteM=1, writeregW=8, regwriteW=1 -> forwardaE=10. Same case with regwriteM=0 -> 01. Case rsE=0 with both stages writing reg 0 -> 00.
- Load-use: memtoregE=1, rtE=9, rsD=9 -> stallF=stallD=flushE=1, stallE=0. Next cycle with memtoregE=0 -> all deasserted.
- Branch: branchD=1, rsD=4, regwriteE=1, writeregE=4 -> branchstall (stallD=1, flushE=1). Case writeregM=4, regwriteM=1, memtoregM=0 -> no stall, forwardaD=1.
- DIV: divE=1 in IDLE -> div_start=1 for exactly 1 cycle. stallE=flushM=1 with flushE=0 until div_done at cycle 5, then release in DONE. With HAZARD_PERF_EN, div_stall_cnt=6.
- Back-to-back DIVs give two div_start pulses separated by the DONE and IDLE cycles. Asserting rst during BUSY -> state IDLE, div_start=0, and a later div_done causes no stall.
